// File: rtl/if_fetch_unit.sv
// Instruction fetch: PC register, imem address, and a direct-mapped
// BTB of 2-bit saturating counters that predicts the next fetch PC.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BTB_IDX_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic        predictedTaken_out,
    output logic [31:0] predictedTarget_out
);

    localparam int N     = 1 << BTB_IDX_W;
    localparam int TAG_W = 30 - BTB_IDX_W;

    logic [31:0]          pc;
    logic [31:0]          next_pc;
    logic [N-1:0]         btb_valid;
    logic [TAG_W-1:0]     btb_tag    [N];
    logic [31:0]          btb_target [N];
    logic [1:0]           btb_ctr    [N];

    logic [BTB_IDX_W-1:0] idx;
    logic [TAG_W-1:0]     tag;
    logic                 hit;
    logic                 pred_taken;
    logic [31:0]          pred_target;

    logic [BTB_IDX_W-1:0] u_idx;
    logic [TAG_W-1:0]     u_tag;
    logic                 u_hit;
    logic [31:0]          u_target;
    logic [31:0]          r_pc;
    logic                 unused_low_bits;

    assign idx         = pc[BTB_IDX_W+1:2];
    assign tag         = pc[31:BTB_IDX_W+2];
    assign hit         = btb_valid[idx] && (btb_tag[idx] == tag);
    assign pred_taken  = hit && btb_ctr[idx][1];
    assign pred_target = pred_taken ? btb_target[idx] : pc + 32'd4;

    assign u_idx    = upd_pc[BTB_IDX_W+1:2];
    assign u_tag    = upd_pc[31:BTB_IDX_W+2];
    assign u_hit    = btb_valid[u_idx] && (btb_tag[u_idx] == u_tag);
    assign u_target = {upd_target[31:2], 2'b00};
    assign r_pc     = {redirect_pc[31:2], 2'b00};

    assign unused_low_bits = ^{upd_pc[1:0], upd_target[1:0], redirect_pc[1:0]};

    assign imem_addr           = pc;
    assign pc_out              = pc;
    assign instr_out           = imem_rdata;
    assign predictedTaken_out  = pred_taken;
    assign predictedTarget_out = pred_target;

    // Redirect wins over stall so a flush is never lost behind a hold.
    always_comb begin
        next_pc = pred_target;
        if (redirect_valid) begin
            next_pc = r_pc;
        end else if (stall) begin
            next_pc = pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= {RESET_PC[31:2], 2'b00};
        end else begin
            pc <= next_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btb_valid <= '0;
            for (int i = 0; i < N; i++) begin
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
                btb_ctr[i]    <= 2'b01;
            end
        end else if (upd_valid) begin
            if (u_hit) begin
                if (upd_taken) begin
                    btb_target[u_idx] <= u_target;
                    if (btb_ctr[u_idx] != 2'b11) begin
                        btb_ctr[u_idx] <= btb_ctr[u_idx] + 2'd1;
                    end
                end else if (btb_ctr[u_idx] != 2'b00) begin
                    btb_ctr[u_idx] <= btb_ctr[u_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                // Allocation evicts whatever aliased into this slot.
                btb_valid[u_idx]  <= 1'b1;
                btb_tag[u_idx]    <= u_tag;
                btb_target[u_idx] <= u_target;
                btb_ctr[u_idx]    <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: randomized and directed fetch,
// stall, redirect and BTB training against a table-based model.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        predictedTaken_out;
    logic [31:0] predictedTarget_out;

    if_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .BTB_IDX_W(4)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .stall              (stall),
        .redirect_valid     (redirect_valid),
        .redirect_pc        (redirect_pc),
        .upd_valid          (upd_valid),
        .upd_pc             (upd_pc),
        .upd_taken          (upd_taken),
        .upd_target         (upd_target),
        .imem_addr          (imem_addr),
        .imem_rdata         (imem_rdata),
        .pc_out             (pc_out),
        .instr_out          (instr_out),
        .predictedTaken_out (predictedTaken_out),
        .predictedTarget_out(predictedTarget_out)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        taken;
        logic [31:0] target;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference: one table slot per (pc/4) mod 16, tag = pc/64.
    logic [31:0] m_pc;
    bit          m_valid  [16];
    logic [31:0] m_tag    [16];
    logic [31:0] m_target [16];
    int          m_ctr    [16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int slot(input logic [31:0] a);
        return int'((a / 4) % 16);
    endfunction

    function automatic logic [31:0] tagof(input logic [31:0] a);
        return a / 64;
    endfunction

    function automatic void model_reset();
        m_pc = 32'h0;
        for (int i = 0; i < 16; i++) begin
            m_valid[i]  = 0;
            m_tag[i]    = 0;
            m_target[i] = 0;
            m_ctr[i]    = 1;
        end
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return m_valid[slot(a)] && (m_tag[slot(a)] == tagof(a));
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Inputs change 1ns after the edge; model state tracks the DUT edges.
    task automatic step(input bit r, input bit s, input bit rv,
                        input logic [31:0] rpc, input bit uv,
                        input logic [31:0] upc, input bit ut,
                        input logic [31:0] utg);
        exp_t e;
        int   k;
        @(posedge clk);
        #1;
        rst_n          = r;
        stall          = s;
        redirect_valid = rv;
        redirect_pc    = rpc;
        upd_valid      = uv;
        upd_pc         = upc;
        upd_taken      = ut;
        upd_target     = utg;
        imem_rdata     = $urandom;
        if (!r) model_reset();
        e.pc     = m_pc;
        e.instr  = imem_rdata;
        e.taken  = model_hit(m_pc) && (m_ctr[slot(m_pc)] >= 2);
        e.target = e.taken ? m_target[slot(m_pc)] : m_pc + 32'd4;
        q.push_back(e);
        if (r) begin
            if (rv) m_pc = rpc & ~32'h3;
            else if (!s) m_pc = e.target;
            if (uv) begin
                k = slot(upc);
                if (model_hit(upc)) begin
                    if (ut) begin
                        m_ctr[k]    = (m_ctr[k] < 3) ? m_ctr[k] + 1 : 3;
                        m_target[k] = utg & ~32'h3;
                    end else begin
                        m_ctr[k] = (m_ctr[k] > 0) ? m_ctr[k] - 1 : 0;
                    end
                end else if (ut) begin
                    m_valid[k]  = 1;
                    m_tag[k]    = tagof(upc);
                    m_target[k] = utg & ~32'h3;
                    m_ctr[k]    = 2;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic go(input logic [31:0] a);
        step(1, 0, 1, a, 0, 0, 0, 0);
    endtask

    task automatic train(input logic [31:0] a, input bit t,
                         input logic [31:0] tg);
        step(1, 1, 0, 0, 1, a, t, tg);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("pc_out", pc_out, e.pc);
            check("imem_addr", imem_addr, e.pc);
            check("instr_out", instr_out, e.instr);
            check("pred_taken", {31'b0, predictedTaken_out},
                  {31'b0, e.taken});
            check("pred_target", predictedTarget_out, e.target);
        end
    end

    initial begin
        int budget;
        rst_n = 0; stall = 0; redirect_valid = 0; redirect_pc = 0;
        upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
        imem_rdata = 0;
        model_reset();

        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        idle(2);
        step(1, 1, 1, 32'h100, 0, 0, 0, 0);
        idle(2);

        train(32'h10, 1, 32'h40);
        go(32'h8);
        idle(3);
        train(32'h10, 0, 32'h0);
        go(32'h10);
        idle(1);
        train(32'h10, 1, 32'h40);
        train(32'h10, 1, 32'h40);
        train(32'h10, 0, 32'h0);
        go(32'h10);
        idle(1);

        go(32'h50);
        idle(1);
        train(32'h50, 1, 32'h80);
        go(32'h10);
        idle(1);
        go(32'h50);
        idle(1);

        go(32'h20);
        idle(1);
        step(1, 0, 0, 0, 1, 32'h24, 1, 32'h203);
        go(32'h24);
        idle(1);

        go(32'hFFFF_FFFE);
        idle(2);

        step(1, 0, 0, 0, 1, 32'h30, 1, 32'h300);
        step(0, 0, 0, 0, 1, 32'h30, 1, 32'h300);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        go(32'h30);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 255) << 2) | $urandom_range(0, 3),
                 ($urandom_range(0, 9) < 4),
                 $urandom_range(0, 255) << 2,
                 ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 1023));
        end

        budget = 0;
        while (q.size() > 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d left expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks,
                 errors);
        $finish;
    end

endmodule
